// File: rtl/ex_muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit for EX: shift-add multiply and
// restoring divide on operand magnitudes, with stall/done handshake to the hazard unit.
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      md_op_i,
  input  logic            is_word_op_i,
  input  logic [XLEN-1:0] RD1_i,
  input  logic [XLEN-1:0] RD2_i,
  input  logic [XLEN-1:0] ResultW_i,
  input  logic [XLEN-1:0] ALUResultM_i,
  input  logic [1:0]      ForwardAE_i,
  input  logic [1:0]      ForwardBE_i,
  output logic            stall_o,
  output logic            done_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int NX = XLEN / BITS_PER_CYCLE;
  localparam int NW = 32 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef struct packed {
    logic [1:0] op;
    logic       wop;
    logic       neg_q;  // negate product / quotient
    logic       neg_r;  // negate remainder
  } ctx_t;

  state_e            state_q;
  ctx_t              ctx_q;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d, quo_q, quo_d, rem_q, rem_d, dvsr_q, result_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN:0]     rtmp;

  function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] rd,
                                          input logic [XLEN-1:0] w, input logic [XLEN-1:0] m);
    case (sel)
      2'b01:   return w;
      2'b10:   return m;
      default: return rd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
    logic [XLEN-1:0] o;
    for (int i = 0; i < XLEN; i++) o[i] = (w && i >= 32) ? v[31] : v[i];
    return o;
  endfunction

  // Cycle-0 decode: forwarding, word masking, magnitudes and no-iteration cases
  logic [XLEN-1:0] a_fw, b_fw, msk, a_m, b_m, mag_a, mag_b, w_min, spec_res;
  logic            wop, a_sgn, b_sgn, sa, sb, div0, ovf;

  always_comb begin
    a_fw  = fwd(ForwardAE_i, RD1_i, ResultW_i, ALUResultM_i);
    b_fw  = fwd(ForwardBE_i, RD2_i, ResultW_i, ALUResultM_i);
    wop   = (XLEN == 64) && is_word_op_i;
    msk   = '0;
    for (int i = 0; i < XLEN; i++) msk[i] = !wop || (i < 32);
    a_m   = a_fw & msk;
    b_m   = b_fw & msk;
    w_min = '0;
    w_min[wop ? 31 : XLEN-1] = 1'b1;
    a_sgn = md_op_i inside {3'b001, 3'b010, 3'b100, 3'b110};
    b_sgn = md_op_i inside {3'b001, 3'b100, 3'b110};
    sa    = a_sgn && ((a_m & w_min) != '0);
    sb    = b_sgn && ((b_m & w_min) != '0);
    mag_a = sa ? ((-a_m) & msk) : a_m;
    mag_b = sb ? ((-b_m) & msk) : b_m;
    div0  = md_op_i[2] && (b_m == '0);
    ovf   = md_op_i[2] && !md_op_i[0] && (a_m == w_min) && (b_m == msk);
    if (md_op_i[1]) spec_res = div0 ? a_m : '0;
    else            spec_res = div0 ? '1 : a_m;
    spec_res = sext_w(spec_res, wop);
  end

  // One iteration: BITS_PER_CYCLE multiplier bits and quotient bits per cycle
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    quo_d = quo_q;
    rtmp  = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) acc_d = acc_d + (mcand_q << k);
      rtmp  = {rem_d, quo_d[XLEN-1]};
      quo_d = {quo_d[XLEN-2:0], 1'b0};
      if (rtmp >= {1'b0, dvsr_q}) begin
        rtmp     = rtmp - {1'b0, dvsr_q};
        quo_d[0] = 1'b1;
      end
      rem_d = rtmp[XLEN-1:0];
    end
    mcand_d  = mcand_q << BITS_PER_CYCLE;
    mplier_d = mplier_q >> BITS_PER_CYCLE;
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, quo_s, rem_s, fin_res;

  always_comb begin
    prod    = ctx_q.neg_q ? -acc_d : acc_d;
    mul_res = (ctx_q.op == 2'b00) ? prod[XLEN-1:0] : XLEN'(prod >> (ctx_q.wop ? 32 : XLEN));
    quo_s   = ctx_q.neg_q ? -quo_d : quo_d;
    rem_s   = ctx_q.neg_r ? -rem_d : rem_d;
    fin_res = sext_w((state_q == S_MUL) ? mul_res : (ctx_q.op[1] ? rem_s : quo_s), ctx_q.wop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctx_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          ctx_q <= '{op: md_op_i[1:0], wop: wop, neg_q: sa ^ sb, neg_r: sa};
          cnt_q <= wop ? CW'(NW - 1) : CW'(NX - 1);
          if (div0 || ovf) begin
            result_q <= spec_res;
            state_q  <= S_DONE;
          end else if (md_op_i[2]) begin
            // dividend MSB-aligned so word ops shift out through the same top bit
            rem_q   <= '0;
            quo_q   <= wop ? (mag_a << (XLEN - 32)) : mag_a;
            dvsr_q  <= mag_b;
            state_q <= S_DIV;
          end else begin
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, mag_a};
            mplier_q <= mag_b;
            state_q  <= S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          rem_q    <= rem_d;
          quo_q    <= quo_d;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= fin_res;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o   = (state_q == S_DONE);
  assign stall_o  = !flush_i && ((start_i && state_q == S_IDLE) || busy_o);
  assign result_o = result_q;

endmodule
